vl_result_tracker: RTL and testbench

- Consumer-side counterpart of the per-lane valid-mask generator in the vector control unit.
- Sits at the lane result return path and receives per-lane result-valid masks, one element group (VLANE_NUM elements) per beat.
- Checks each mask against the mask the configured vl requires, and counts reduction partial results.
- Pulses done when the whole vector has returned; flags any mismatch as a sticky error.

---
 rtl/vl_result_tracker.sv | 184 ++++++++++++++++++
 tb/tb_vl_result_tracker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vl_result_tracker.sv
// Result-return tracker: checks per-lane valid masks against the configured vl,
// counts reduction partials, pulses done. Optional watchdog: RESULT_TIMEOUT_EN.
module vl_result_tracker #(
  parameter int MAX_VL_PER_LANE = 256,
  parameter int VLANE_NUM       = 8,
  parameter int TIMEOUT_CYCLES  = 1024,
  localparam int LG    = $clog2(VLANE_NUM),
  localparam int VL_W  = $clog2(VLANE_NUM * MAX_VL_PER_LANE),
  localparam int EG_W  = $clog2(MAX_VL_PER_LANE),
  localparam int GRP_W = EG_W + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [VL_W-1:0]      vl_i,
  input  logic                 reduction_i,
  input  logic [VLANE_NUM-1:0] lane_valid_i,
  input  logic                 partial_valid_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 mismatch_o,
  output logic [EG_W-1:0]      err_group_o,
  output logic                 timeout_o
);

  localparam int DIV_W = VL_W - LG;

  typedef enum logic [1:0] {IDLE, COLLECT, PARTIAL, DONE} state_t;

  state_t               state, state_n;
  logic [DIV_W-1:0]     div_q;
  logic [LG-1:0]        mod_q;
  logic [GRP_W-1:0]     last_q;
  logic [LG-1:0]        pexp_q;
  logic [GRP_W-1:0]     grp_q, grp_n;
  logic [LG-1:0]        pcnt_q, pcnt_n;
  logic                 mismatch_q, mis_n;
  logic [EG_W-1:0]      errg_q, errg_n;
  logic                 load;
  logic                 tmo_hit;

  logic [DIV_W-1:0]     in_div;
  logic [LG-1:0]        in_mod;
  logic [GRP_W-1:0]     in_last;
  logic [LG-1:0]        in_pexp;
  logic [VLANE_NUM-1:0] exp_mask;
  logic                 beat;
  logic                 activity;

  function automatic logic [VLANE_NUM-1:0] low_mask(input logic [LG-1:0] n);
    logic [VLANE_NUM-1:0] m;
    m = '0;
    for (int i = 0; i < VLANE_NUM; i++)
      if (i < int'(n)) m[i] = 1'b1;
    return m;
  endfunction

  assign in_div   = vl_i[VL_W-1:LG];
  assign in_mod   = vl_i[LG-1:0];
  assign in_last  = GRP_W'(in_div) + GRP_W'(in_mod != '0);
  assign beat     = |lane_valid_i;
  assign activity = beat | partial_valid_i;

  // Partials expected: a short vector (single partial group) yields fewer lanes.
  always_comb begin
    in_pexp = LG'(VLANE_NUM - 1);
    if (!reduction_i || vl_i == '0) in_pexp = '0;
    else if (in_div == '0)          in_pexp = LG'(in_mod - 1'b1);
  end

  always_comb begin
    exp_mask = '1;
    if (grp_q == GRP_W'(div_q) && mod_q != '0) exp_mask = low_mask(mod_q);
  end

  always_comb begin
    state_n = state;
    grp_n   = grp_q;
    pcnt_n  = pcnt_q;
    mis_n   = mismatch_q;
    errg_n  = errg_q;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          grp_n   = '0;
          pcnt_n  = '0;
          mis_n   = 1'b0;
          errg_n  = '0;
          state_n = (vl_i == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (beat) begin
          grp_n = GRP_W'(grp_q + 1'b1);
          if (lane_valid_i != exp_mask) begin
            mis_n = 1'b1;
            if (!mismatch_q) errg_n = grp_q[EG_W-1:0];
          end
          if (grp_q == GRP_W'(last_q - 1'b1))
            state_n = (pexp_q != '0) ? PARTIAL : DONE;
        end
        if (partial_valid_i) begin
          mis_n = 1'b1;
          if (!mismatch_q) errg_n = grp_q[EG_W-1:0];
        end
      end
      PARTIAL: begin
        if (partial_valid_i) begin
          pcnt_n = LG'(pcnt_q + 1'b1);
          if (LG'(pcnt_q + 1'b1) == pexp_q) state_n = DONE;
        end
        if (beat) mis_n = 1'b1;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (tmo_hit) state_n = DONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      grp_q      <= '0;
      pcnt_q     <= '0;
      mismatch_q <= 1'b0;
      errg_q     <= '0;
      div_q      <= '0;
      mod_q      <= '0;
      last_q     <= '0;
      pexp_q     <= '0;
    end else begin
      state      <= state_n;
      grp_q      <= grp_n;
      pcnt_q     <= pcnt_n;
      mismatch_q <= mis_n;
      errg_q     <= errg_n;
      if (load) begin
        div_q  <= in_div;
        mod_q  <= in_mod;
        last_q <= in_last;
        pexp_q <= in_pexp;
      end
    end
  end

`ifdef RESULT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_q;
  logic          timeout_q;
  logic          waiting;

  assign waiting = (state == COLLECT) || (state == PARTIAL);
  assign tmo_hit = waiting && !activity && (idle_q == TW'(TIMEOUT_CYCLES - 1));

  // Idle counter only advances while waiting for returns with nothing arriving.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!waiting || activity) idle_q <= '0;
      else                      idle_q <= TW'(idle_q + 1'b1);
      if (load)         timeout_q <= 1'b0;
      else if (tmo_hit) timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0) & activity;
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign mismatch_o  = mismatch_q;
  assign err_group_o = errg_q;

endmodule

// File: tb/tb_vl_result_tracker.sv
// Directed bench for vl_result_tracker: expected completion status is queued at
// start and checked when done_o pulses.
module tb_vl_result_tracker;

  localparam int MAXVL = 256;
  localparam int NL    = 8;
  localparam int TMO   = 16;
  localparam int VL_W  = $clog2(NL * MAXVL);
  localparam int EG_W  = $clog2(MAXVL);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [VL_W-1:0] vl = '0;
  logic            reduction = 1'b0;
  logic [NL-1:0]   lane_valid = '0;
  logic            partial_valid = 1'b0;
  logic            busy, done, mismatch, timeout;
  logic [EG_W-1:0] err_group;

  typedef struct {
    logic            mis;
    logic [EG_W-1:0] errg;
    logic            tmo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  vl_result_tracker #(
    .MAX_VL_PER_LANE(MAXVL),
    .VLANE_NUM(NL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .vl_i(vl),
    .reduction_i(reduction),
    .lane_valid_i(lane_valid),
    .partial_valid_i(partial_valid),
    .busy_o(busy),
    .done_o(done),
    .mismatch_o(mismatch),
    .err_group_o(err_group),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op_start(input int v, input logic red, input logic emis,
                          input int eerr, input logic etmo);
    exp_t e;
    e.mis  = emis;
    e.errg = EG_W'(eerr);
    e.tmo  = etmo;
    sb.push_back(e);
    start     = 1'b1;
    vl        = VL_W'(v);
    reduction = red;
    step();
    start = 1'b0;
  endtask

  task automatic beat(input logic [NL-1:0] m);
    lane_valid = m;
    step();
    lane_valid = '0;
  endtask

  task automatic pulse();
    partial_valid = 1'b1;
    step();
    partial_valid = 1'b0;
  endtask

  task automatic expect_done(input string tag);
    exp_t e;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_sb_pending"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_mismatch"}, mismatch, e.mis);
      chk({tag, "_err_group"}, err_group, e.errg);
      chk({tag, "_timeout"}, timeout, e.tmo);
    end
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_done_low"}, done, 0);
    chk({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_err_group", err_group, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;
    step();

    // vl=20: groups FF, FF, 0F
    op_start(20, 1'b0, 1'b0, 0, 1'b0);
    chk("op1_busy", busy, 1);
    beat(8'hFF);
    chk("op1_b0_done", done, 0);
    beat(8'hFF);
    chk("op1_b1_done", done, 0);
    beat(8'h0F);
    expect_done("op1");
    step();
    expect_idle("op1_after");

    // vl=16: exactly two full groups
    op_start(16, 1'b0, 1'b0, 0, 1'b0);
    beat(8'hFF);
    chk("op2_b0_done", done, 0);
    beat(8'hFF);
    expect_done("op2");
    step();
    expect_idle("op2_after");

    // vl=5 reduction: one group 1F, then 4 partials
    op_start(5, 1'b1, 1'b0, 0, 1'b0);
    beat(8'h1F);
    chk("op3_partial_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      pulse();
      chk("op3_pulse_busy", busy, 1);
      chk("op3_pulse_done", done, 0);
    end
    pulse();
    expect_done("op3");
    step();
    expect_idle("op3_after");

    // vl=17 reduction: groups FF FF 01, then 7 partials
    op_start(17, 1'b1, 1'b0, 0, 1'b0);
    beat(8'hFF);
    beat(8'hFF);
    beat(8'h01);
    chk("op4_partial_busy", busy, 1);
    for (int i = 0; i < 6; i++) pulse();
    chk("op4_pulse6_done", done, 0);
    pulse();
    expect_done("op4");
    step();

    // vl=20 with wrong mask in group 1
    op_start(20, 1'b0, 1'b1, 1, 1'b0);
    beat(8'hFF);
    chk("op5_b0_mismatch", mismatch, 0);
    beat(8'h7F);
    chk("op5_b1_mismatch", mismatch, 1);
    chk("op5_b1_err_group", err_group, 1);
    beat(8'h0F);
    expect_done("op5");
    step();

    // vl=0 completes immediately and clears the sticky mismatch
    op_start(0, 1'b0, 1'b0, 0, 1'b0);
    expect_done("op6");
    start = 1'b1;
    vl    = VL_W'(8);
    step();
    start = 1'b0;
    expect_idle("op6_start_in_done_ignored");

    // start during COLLECT is ignored
    op_start(8, 1'b0, 1'b0, 0, 1'b0);
    start = 1'b1;
    vl    = '0;
    step();
    start = 1'b0;
    chk("op7_start_ignored_busy", busy, 1);
    chk("op7_start_ignored_done", done, 0);
    beat(8'hFF);
    expect_done("op7");
    step();

    // partial_valid during COLLECT is an error at the current group
    op_start(16, 1'b0, 1'b1, 1, 1'b0);
    beat(8'hFF);
    pulse();
    chk("op8_partial_in_collect", mismatch, 1);
    beat(8'hFF);
    expect_done("op8");
    step();

    // asynchronous reset mid-operation
    start     = 1'b1;
    vl        = VL_W'(20);
    reduction = 1'b0;
    step();
    start = 1'b0;
    beat(8'h7F);
    chk("op9_pre_rst_mismatch", mismatch, 1);
    #2 rst = 1'b1;
    #1;
    chk("op9_rst_busy", busy, 0);
    chk("op9_rst_mismatch", mismatch, 0);
    chk("op9_rst_err_group", err_group, 0);
    #1 rst = 1'b0;
    step();
    chk("op9_post_rst_busy", busy, 0);

`ifdef RESULT_TIMEOUT_EN
    op_start(8, 1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < TMO - 1; i++) step();
    chk("tmo_early_done", done, 0);
    chk("tmo_early_flag", timeout, 0);
    step();
    expect_done("tmo");
    step();
    expect_idle("tmo_after");
    op_start(8, 1'b0, 1'b0, 0, 1'b0);
    chk("tmo_cleared_by_start", timeout, 0);
    beat(8'hFF);
    expect_done("tmo_next");
    step();
`else
    chk("no_tmo_flag", timeout, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
